// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory address and
// registers each fetched word into a valid/ready output stage. Optional FETCH_PERF_EN adds perf counters.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] IMem_Address,
  input  logic [31:0] IMem_Instruction,
  input  logic        Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        IF_Ready,
  output logic        IF_Valid,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCPlus4,
  output logic        Done,
  output logic        Fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Stall_Count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [29:0] LIMIT_WORD = 30'(IMEM_WORDS);

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  state_t      state;
  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pcp4_p1;
  logic        vld_p1;
  logic        done_r;
  logic        fault_r;

  logic        xfer;
  logic        blocked;
  logic        misaligned;
  logic        end_of_mem;

  assign xfer       = vld_p1 & IF_Ready;
  assign blocked    = vld_p1 & ~IF_Ready;
  assign misaligned = (Redirect_Target[1:0] != 2'b00);
  assign end_of_mem = (pc_p0[31:2] >= LIMIT_WORD);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= RUN;
      pc_p0    <= RESET_PC;
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
      pcp4_p1  <= 32'd0;
      vld_p1   <= 1'b0;
      done_r   <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (Redirect_Valid && misaligned) begin
            state   <= FAULT;
            vld_p1  <= 1'b0;
            fault_r <= 1'b1;
          end else if (Redirect_Valid) begin
            // Redirect overrides a stall and flushes the wrong-path word
            pc_p0  <= Redirect_Target;
            vld_p1 <= 1'b0;
          end else if (!(Stall || blocked)) begin
            // Not blocked here, so any word still held is being accepted this cycle
            if (end_of_mem) begin
              state  <= HALT;
              vld_p1 <= 1'b0;
              done_r <= 1'b1;
            end else begin
              // stage p0 -> p1: capture memory word with its address
              instr_p1 <= IMem_Instruction;
              pc_p1    <= pc_p0;
              pcp4_p1  <= next_word(pc_p0);
              vld_p1   <= 1'b1;
              pc_p0    <= next_word(pc_p0);
            end
          end
        end
        HALT: begin
          if (Redirect_Valid && misaligned) begin
            state   <= FAULT;
            done_r  <= 1'b0;
            fault_r <= 1'b1;
          end else if (Redirect_Valid) begin
            state  <= RUN;
            pc_p0  <= Redirect_Target;
            done_r <= 1'b0;
          end
        end
        FAULT: begin
          vld_p1 <= 1'b0;
        end
        default: begin
          state   <= FAULT;
          vld_p1  <= 1'b0;
          done_r  <= 1'b0;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (xfer) fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == RUN) && (Stall || blocked)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign Fetch_Count = fetch_cnt;
  assign Stall_Count = stall_cnt;
`endif

  assign IMem_Address   = pc_p0;
  assign IF_Valid       = vld_p1;
  assign IF_Instruction = instr_p1;
  assign IF_PC          = pc_p1;
  assign IF_PCPlus4     = pcp4_p1;
  assign Done           = done_r;
  assign Fault          = fault_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed stimulus pushes expected transfers,
// a negedge monitor pops and compares each handshake.
module tb_instr_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] IMem_Address;
  logic [31:0] IMem_Instruction;
  logic        Stall;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        IF_Ready;
  logic        IF_Valid;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCPlus4;
  logic        Done;
  logic        Fault;
`ifdef FETCH_PERF_EN
  logic [31:0] Fetch_Count;
  logic [31:0] Stall_Count;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[32];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 Clk = ~Clk;

  assign IMem_Instruction = (IMem_Address[31:7] == 25'd0) ? mem[IMem_Address[6:2]] : 32'hDEAD_BEEF;

  instr_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(32)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .IMem_Address    (IMem_Address),
    .IMem_Instruction(IMem_Instruction),
    .Stall           (Stall),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .IF_Ready        (IF_Ready),
    .IF_Valid        (IF_Valid),
    .IF_Instruction  (IF_Instruction),
    .IF_PC           (IF_PC),
    .IF_PCPlus4      (IF_PCPlus4),
    .Done            (Done),
    .Fault           (Fault)
`ifdef FETCH_PERF_EN
    ,
    .Fetch_Count     (Fetch_Count),
    .Stall_Count     (Stall_Count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: a transfer happens at the next posedge when valid and ready are both high now
  always @(negedge Clk) begin
    if (Rst === 1'b1 && IF_Valid === 1'b1 && IF_Ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got transfer pc=%h instr=%h, required none", IF_PC, IF_Instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", IF_Instruction, e.instr);
        chk("sb_pc", IF_PC, e.pc);
        chk("sb_pcplus4", IF_PCPlus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 4);
    Rst = 1'b0; Stall = 1'b0; Redirect_Valid = 1'b0; Redirect_Target = 32'd0; IF_Ready = 1'b0;
    step();
    step();
    chk("rst_valid", IF_Valid, 0);
    chk("rst_instr", IF_Instruction, 0);
    chk("rst_pc", IF_PC, 0);
    chk("rst_pcplus4", IF_PCPlus4, 0);
    chk("rst_done", Done, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_addr", IMem_Address, 32'h0);

    // Sequential fetch, then a 3-cycle back-pressure hold at word 0x8
    push(32'h0, 32'h0); push(32'h4, 32'h4); push(32'h8, 32'h8); push(32'hC, 32'hC);
    Rst = 1'b1; IF_Ready = 1'b1;
    step();
    chk("first_valid", IF_Valid, 1);
    chk("first_pc", IF_PC, 32'h0);
    step();
    step();
    chk("pre_hold_instr", IF_Instruction, 32'h8);
    IF_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_instr", IF_Instruction, 32'h8);
      chk("hold_valid", IF_Valid, 1);
      chk("hold_addr", IMem_Address, 32'hC);
    end
    IF_Ready = 1'b1;
    step();
    chk("resume_instr", IF_Instruction, 32'hC);
    step();

    // Redirect during stall flushes the held word 0x10
    for (int a = 32'h40; a <= 32'h7C; a += 4) push(32'(a), 32'(a));
    Stall = 1'b1; IF_Ready = 1'b0; Redirect_Valid = 1'b1; Redirect_Target = 32'h40;
    step();
    chk("redir_valid", IF_Valid, 0);
    chk("redir_addr", IMem_Address, 32'h40);
    Stall = 1'b0; Redirect_Valid = 1'b0; IF_Ready = 1'b1;
    step();
    chk("redir_pc", IF_PC, 32'h40);

    // Run off the end of memory
    for (int i = 0; i < 40 && Done !== 1'b1; i++) step();
    chk("halt_done", Done, 1);
    chk("halt_valid", IF_Valid, 0);
    chk("halt_addr", IMem_Address, 32'h80);
    step();
    chk("halt_frozen", IMem_Address, 32'h80);
    chk("halt_done2", Done, 1);

    for (int i = 0; i < 32; i++) mem[i] = 32'h5A00_0000 | 32'(i * 4);
    push(32'h5A00_0000, 32'h0); push(32'h5A00_0004, 32'h4); push(32'h5A00_0008, 32'h8);
    Redirect_Valid = 1'b1; Redirect_Target = 32'h0;
    step();
    chk("unhalt_done", Done, 0);
    chk("unhalt_valid", IF_Valid, 0);
    chk("unhalt_addr", IMem_Address, 32'h0);
    Redirect_Valid = 1'b0;
    step();
    step();
    step();

    // Misaligned redirect: sticky fault
    Redirect_Valid = 1'b1; Redirect_Target = 32'h42;
    step();
    chk("fault_set", Fault, 1);
    chk("fault_valid", IF_Valid, 0);
    chk("fault_done", Done, 0);
    chk("fault_addr", IMem_Address, 32'hC);
    Redirect_Target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      Stall = 1'(i);
      step();
    end
    chk("fault_sticky", Fault, 1);
    chk("fault_sticky_valid", IF_Valid, 0);
    chk("fault_sticky_addr", IMem_Address, 32'hC);
    Redirect_Valid = 1'b0;

    // Reset wins even with stall asserted
    Rst = 1'b0; Stall = 1'b1; IF_Ready = 1'b0;
    step();
    chk("rst2_fault", Fault, 0);
    chk("rst2_addr", IMem_Address, 32'h0);
    chk("rst2_valid", IF_Valid, 0);
    chk("rst2_pc", IF_PC, 0);
    chk("rst2_instr", IF_Instruction, 0);
`ifdef FETCH_PERF_EN
    chk("rst2_fetch_cnt", Fetch_Count, 0);
    chk("rst2_stall_cnt", Stall_Count, 0);
`endif

    // 10 transfers with 4 stall cycles in the middle
    for (int a = 0; a <= 32'h24; a += 4) push(32'h5A00_0000 | 32'(a), 32'(a));
    Rst = 1'b1; Stall = 1'b0; IF_Ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("prestall_pc", IF_PC, 32'h10);
    Stall = 1'b1; IF_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc", IF_PC, 32'h10);
      chk("stall_addr", IMem_Address, 32'h14);
    end
    Stall = 1'b0; IF_Ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
`ifdef FETCH_PERF_EN
    chk("perf_fetch", Fetch_Count, 32'd10);
    chk("perf_stall", Stall_Count, 32'd4);
`endif
    IF_Ready = 1'b0;
    step();
    step();
    chk("final_valid", IF_Valid, 1);
    chk("final_pc", IF_PC, 32'h28);
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
